// File: rtl/pim_pkg.sv
// Shared state encoding and act-vector indexing for the PIM MAC sequencer.
package pim_pkg;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] IDLE   = 3'd0;
    localparam logic [ST_W-1:0] RUN    = 3'd1;
    localparam logic [ST_W-1:0] DRAIN  = 3'd2;
    localparam logic [ST_W-1:0] SAMPLE = 3'd3;
    localparam logic [ST_W-1:0] DONE   = 3'd4;

    localparam int DRAIN_CYCLES = 1;

    // Flat bit position of activation bit 'plane' of row 'row'.
    function automatic int act_bit_idx(input int row, input int plane, input int ibits);
        return row * ibits + plane;
    endfunction

endpackage

// File: rtl/pim_bitplane_sel.sv
// Selects one activation bit plane as the macro rwl vector; with PIM_ZERO_PLANE_SKIP_EN
// it also reports how many low-order planes a job actually needs.
module pim_bitplane_sel
    import pim_pkg::*;
#(
    parameter int PDEPTH = 256,
    parameter int IBITS  = 8,
    parameter int KW     = 4
) (
    input  logic [PDEPTH*IBITS-1:0] act_i,
    input  logic [KW-1:0]           k_i,
    output logic [PDEPTH-1:0]       plane_o
`ifdef PIM_ZERO_PLANE_SKIP_EN
    ,
    output logic [KW-1:0]           nplanes_o,
    output logic                    any_nz_o
`endif
);

    genvar gi;

    generate
        for (gi = 0; gi < PDEPTH; gi++) begin : g_row
            logic bit_sel;
            always_comb begin
                bit_sel = 1'b0;
                for (int b = 0; b < IBITS; b++) begin
                    if (k_i == KW'(b)) begin
                        bit_sel = act_i[act_bit_idx(gi, b, IBITS)];
                    end
                end
            end
            assign plane_o[gi] = bit_sel;
        end
    endgenerate

`ifdef PIM_ZERO_PLANE_SKIP_EN
    logic [IBITS-1:0] plane_nz;

    generate
        for (gi = 0; gi < IBITS; gi++) begin : g_plane
            logic nz;
            always_comb begin
                nz = 1'b0;
                for (int r = 0; r < PDEPTH; r++) begin
                    nz = nz | act_i[act_bit_idx(r, gi, IBITS)];
                end
            end
            assign plane_nz[gi] = nz;
        end
    endgenerate

    // Highest set plane wins; the count is that index plus one.
    always_comb begin
        nplanes_o = '0;
        for (int b = 0; b < IBITS; b++) begin
            if (plane_nz[b]) begin
                nplanes_o = KW'(b + 1);
            end
        end
    end

    assign any_nz_o = |plane_nz;
`endif

endmodule

// File: rtl/pim_mac_sequencer.sv
// Initiator-side controller for the PIM macro: weight loads and bit-serial MAC jobs.
// Optional trailing-zero-plane skipping is enabled by defining PIM_ZERO_PLANE_SKIP_EN.
module pim_mac_sequencer
    import pim_pkg::*;
#(
    parameter int AWIDTH = 8,
    parameter int PDEPTH = 1 << AWIDTH,
    parameter int PWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int IBITS  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [AWIDTH-1:0]       wr_addr,
    input  logic [PWIDTH-1:0]       wr_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PDEPTH*IBITS-1:0] in_act,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DWIDTH-1:0]       res_data,
    output logic [AWIDTH-1:0]       pim_addr,
    output logic [PWIDTH-1:0]       pim_d,
    output logic                    pim_w_en,
    output logic                    pim_p_en,
    output logic [PDEPTH-1:0]       pim_rwl,
    input  logic [DWIDTH-1:0]       pim_mac_out
);

    localparam int KW = $clog2(IBITS + 1);

    logic [ST_W-1:0]          state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic [KW-1:0]            nplanes_q, nplanes_d;
    logic [PDEPTH*IBITS-1:0]  act_q, act_d;
    logic [AWIDTH-1:0]        pim_addr_q, pim_addr_d;
    logic [PWIDTH-1:0]        pim_d_q, pim_d_d;
    logic                     pim_w_en_q, pim_w_en_d;
    logic                     pim_p_en_q, pim_p_en_d;
    logic [PDEPTH-1:0]        pim_rwl_q, pim_rwl_d;
    logic                     res_valid_q, res_valid_d;
    logic [DWIDTH-1:0]        res_data_q, res_data_d;

    logic                     idle;
    logic                     wr_hs;
    logic                     in_hs;
    logic [PDEPTH*IBITS-1:0]  sel_act;
    logic [KW-1:0]            sel_k;
    logic [PDEPTH-1:0]        sel_plane;
    logic [KW-1:0]            job_planes;

    assign idle     = (state_q == IDLE);
    assign wr_ready = idle;
    assign in_ready = idle && !wr_valid;
    assign wr_hs    = wr_valid && idle;
    assign in_hs    = in_valid && in_ready;

    // In IDLE the selector looks at the incoming job so plane 0 is on rwl right after accept.
    assign sel_act = idle ? in_act : act_q;
    assign sel_k   = idle ? '0 : k_q + KW'(1);

`ifdef PIM_ZERO_PLANE_SKIP_EN
    logic any_nz;

    pim_bitplane_sel #(
        .PDEPTH (PDEPTH),
        .IBITS  (IBITS),
        .KW     (KW)
    ) u_sel (
        .act_i     (sel_act),
        .k_i       (sel_k),
        .plane_o   (sel_plane),
        .nplanes_o (job_planes),
        .any_nz_o  (any_nz)
    );
`else
    pim_bitplane_sel #(
        .PDEPTH (PDEPTH),
        .IBITS  (IBITS),
        .KW     (KW)
    ) u_sel (
        .act_i   (sel_act),
        .k_i     (sel_k),
        .plane_o (sel_plane)
    );

    assign job_planes = KW'(IBITS);
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        nplanes_d   = nplanes_q;
        act_d       = act_q;
        pim_addr_d  = pim_addr_q;
        pim_d_d     = pim_d_q;
        pim_w_en_d  = 1'b0;
        pim_p_en_d  = 1'b0;
        pim_rwl_d   = '0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        case (state_q)
            IDLE: begin
                if (wr_hs) begin
                    pim_w_en_d = 1'b1;
                    pim_addr_d = wr_addr;
                    pim_d_d    = wr_data;
                end else if (in_hs) begin
                    act_d     = in_act;
                    k_d       = '0;
                    nplanes_d = job_planes;
`ifdef PIM_ZERO_PLANE_SKIP_EN
                    if (!any_nz) begin
                        state_d     = DONE;
                        res_valid_d = 1'b1;
                        res_data_d  = '0;
                    end else
`endif
                    begin
                        state_d    = RUN;
                        pim_p_en_d = 1'b1;
                        pim_rwl_d  = sel_plane;
                    end
                end
            end

            RUN: begin
                if (k_q == nplanes_q - KW'(1)) begin
                    state_d = DRAIN;
                    k_d     = '0;
                end else begin
                    k_d        = k_q + KW'(1);
                    pim_p_en_d = 1'b1;
                    pim_rwl_d  = sel_plane;
                end
            end

            // p_en low for a cycle lets the macro latch its sum into mac_out.
            DRAIN: begin
                if (k_q == KW'(DRAIN_CYCLES - 1)) begin
                    state_d = SAMPLE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end

            SAMPLE: begin
                state_d     = DONE;
                res_valid_d = 1'b1;
                res_data_d  = pim_mac_out;
            end

            DONE: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            nplanes_q   <= '0;
            act_q       <= '0;
            pim_addr_q  <= '0;
            pim_d_q     <= '0;
            pim_w_en_q  <= 1'b0;
            pim_p_en_q  <= 1'b0;
            pim_rwl_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            nplanes_q   <= nplanes_d;
            act_q       <= act_d;
            pim_addr_q  <= pim_addr_d;
            pim_d_q     <= pim_d_d;
            pim_w_en_q  <= pim_w_en_d;
            pim_p_en_q  <= pim_p_en_d;
            pim_rwl_q   <= pim_rwl_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign pim_addr  = pim_addr_q;
    assign pim_d     = pim_d_q;
    assign pim_w_en  = pim_w_en_q;
    assign pim_p_en  = pim_p_en_q;
    assign pim_rwl   = pim_rwl_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_pim_mac_sequencer.sv
// Directed bench for pim_mac_sequencer with a small behavioural PIM macro attached.
module tb_pim_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_act;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [1:0]  pim_addr;
    logic [7:0]  pim_d;
    logic        pim_w_en;
    logic        pim_p_en;
    logic [3:0]  pim_rwl;
    logic [31:0] pim_mac_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pim_mac_sequencer #(
        .AWIDTH (2),
        .PDEPTH (4),
        .PWIDTH (8),
        .DWIDTH (32),
        .IBITS  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_act      (in_act),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .pim_addr    (pim_addr),
        .pim_d       (pim_d),
        .pim_w_en    (pim_w_en),
        .pim_p_en    (pim_p_en),
        .pim_rwl     (pim_rwl),
        .pim_mac_out (pim_mac_out)
    );

    // Behavioural macro: weight rows, LSB-first shift-accumulate while p_en, latch on p_en low.
    logic [7:0]  mw [4] = '{default: 8'd0};
    logic [31:0] macc = 32'd0;
    logic [31:0] mac_out_m = 32'd0;
    int unsigned mcnt = 0;
    logic [31:0] psum;

    always_comb begin
        psum = 32'd0;
        for (int j = 0; j < 4; j++) begin
            if (pim_rwl[j]) psum = psum + 32'(mw[j]);
        end
    end

    always @(posedge clk) begin
        if (pim_w_en) mw[pim_addr] <= pim_d;
        if (pim_p_en) begin
            macc <= macc + (psum << mcnt);
            mcnt <= mcnt + 1;
        end else begin
            mac_out_m <= macc;
            macc      <= 32'd0;
            mcnt      <= 0;
        end
    end

    assign pim_mac_out = mac_out_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr_rows(input string tag, input logic [31:0] vals);
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 2'(i);
            wr_data  = vals[i*8 +: 8];
            @(posedge clk); #1;
            chk({tag, ".w_en"}, 32'(pim_w_en), 32'd1);
            chk({tag, ".addr"}, 32'(pim_addr), 32'(i));
            chk({tag, ".d"}, 32'(pim_d), 32'(vals[i*8 +: 8]));
            $display("write %s row=%0d data=%0d", tag, i, vals[i*8 +: 8]);
        end
        wr_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".w_en_off"}, 32'(pim_w_en), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk({tag, ".readback"}, 32'(mw[i]), 32'(vals[i*8 +: 8]));
        end
    endtask

    // Offers one job and follows it to the result; rwl_seq packs plane k at [4k+:4].
    task automatic run_job(input string tag, input logic [15:0] act, input logic [15:0] rwl_seq,
                           input int np, input int lat, input logic [31:0] exp_res,
                           input bit hold, input bit poke);
        int n;
        logic [3:0] exp_rwl;
        res_ready = !hold;
        in_act    = act;
        in_valid  = 1'b1;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (res_valid !== 1'b1 && n < 40) begin
            if (n < np) exp_rwl = rwl_seq[n*4 +: 4];
            else        exp_rwl = 4'd0;
            chk({tag, ".p_en"}, 32'(pim_p_en), (n < np) ? 32'd1 : 32'd0);
            chk({tag, ".rwl"}, 32'(pim_rwl), 32'(exp_rwl));
            chk({tag, ".busy_wr_ready"}, 32'(wr_ready), 32'd0);
            if (poke && n == 1) begin
                wr_valid = 1'b1;
                wr_addr  = 2'd2;
                wr_data  = 8'h11;
                #1;
                chk({tag, ".poke_wr_ready"}, 32'(wr_ready), 32'd0);
            end
            if (poke && n == 2) begin
                chk({tag, ".poke_w_en"}, 32'(pim_w_en), 32'd0);
                wr_valid = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(lat));
        chk({tag, ".res_data"}, res_data, exp_res);
        chk({tag, ".done_p_en"}, 32'(pim_p_en), 32'd0);
        $display("job %s act=%04h latency=%0d res=%0d", tag, act, n, res_data);
        if (!hold) begin
            @(posedge clk); #1;
            chk({tag, ".res_valid_drop"}, 32'(res_valid), 32'd0);
            chk({tag, ".idle_wr_ready"}, 32'(wr_ready), 32'd1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = 2'd0;
        wr_data   = 8'd0;
        in_valid  = 1'b0;
        in_act    = 16'd0;
        res_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.w_en", 32'(pim_w_en), 32'd0);
        chk("rst.p_en", 32'(pim_p_en), 32'd0);
        chk("rst.rwl", 32'(pim_rwl), 32'd0);
        chk("rst.addr", 32'(pim_addr), 32'd0);
        chk("rst.d", 32'(pim_d), 32'd0);
        chk("rst.res_valid", 32'(res_valid), 32'd0);
        chk("rst.res_data", res_data, 32'd0);
        chk("rst.wr_ready", 32'(wr_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Rows 0..3 = 3,5,7,1; act (1,2,3,4) -> 3+10+21+4 = 38
        wr_rows("load", 32'h01070503);
        run_job("basic", 16'h4321, 16'h0865, 4, 6, 32'd38, 1'b0, 1'b0);

        // Write and job offered together: write first, job next cycle.
        wr_valid  = 1'b1;
        wr_addr   = 2'd0;
        wr_data   = 8'd3;
        in_valid  = 1'b1;
        in_act    = 16'h4321;
        #1;
        chk("prio.in_ready", 32'(in_ready), 32'd0);
        chk("prio.wr_ready", 32'(wr_ready), 32'd1);
        @(posedge clk); #1;
        chk("prio.w_en", 32'(pim_w_en), 32'd1);
        chk("prio.p_en", 32'(pim_p_en), 32'd0);
        $display("write prio row=0 data=3");
        wr_valid = 1'b0;
        run_job("prio", 16'h4321, 16'h0865, 4, 6, 32'd38, 1'b0, 1'b0);

        // Result held under backpressure.
        run_job("bp", 16'h4321, 16'h0865, 4, 6, 32'd38, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("bp.res_valid", 32'(res_valid), 32'd1);
            chk("bp.res_data", res_data, 32'd38);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.release", 32'(res_valid), 32'd0);
        $display("job bp released res=%0d", res_data);

        // 4 rows * 15 * 255 = 15300; mid-job write must be refused.
        wr_rows("max_load", 32'hFFFFFFFF);
        run_job("max", 16'hFFFF, 16'hFFFF, 4, 6, 32'd15300, 1'b0, 1'b1);
        chk("max.row2_kept", 32'(mw[2]), 32'd255);

        // Async reset at plane 2 of a job.
        wr_rows("reload", 32'h01070503);
        in_act   = 16'h4321;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mrst.pre_p_en", 32'(pim_p_en), 32'd1);
        chk("mrst.pre_rwl", 32'(pim_rwl), 32'd8);
        rst_n = 1'b0;
        #1;
        chk("mrst.p_en", 32'(pim_p_en), 32'd0);
        chk("mrst.rwl", 32'(pim_rwl), 32'd0);
        chk("mrst.res_valid", 32'(res_valid), 32'd0);
        chk("mrst.wr_ready", 32'(wr_ready), 32'd1);
        $display("reset asserted mid-run");
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_job("rerun", 16'h4321, 16'h0865, 4, 6, 32'd38, 1'b0, 1'b0);

`ifdef PIM_ZERO_PLANE_SKIP_EN
        // act (1,1,0,0): one plane, 3+5 = 8
        run_job("skip1", 16'h0011, 16'h0003, 1, 3, 32'd8, 1'b0, 1'b0);
        run_job("skip0", 16'h0000, 16'h0000, 0, 0, 32'd0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
